uart_tx_fifo: RTL and testbench

- Transmit-side byte buffer and launch controller directly upstream of the UART transmitter.
- Accepts bytes from the host/bus write port into a synchronous FIFO.
- Presents the head byte on txd_in and pulses tx_start. Pops the byte when the transmitter reports tx_ok.
- Lets software queue up to DEPTH bytes without polling per-byte completion.

---
 rtl/uart_tx_fifo_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 96 +++++++++
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_pkg
// Brief    : Shared launch-FSM encodings and default sizing for uart_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

    localparam int C_DEF_DEPTH  = 16;
    localparam int C_DEF_AW     = 4;
    localparam int C_DEF_THRESH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Byte FIFO with sticky overflow; push is accepted when full if a
//            pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = C_DEF_DEPTH,
    parameter int AW    = C_DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          ovf_clr,
    output logic [7:0]    head_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = pop && !w_empty;
    // A simultaneous pop frees the head slot, so a full FIFO may still accept.
    assign w_push  = push && (!w_full || w_pop);
    assign w_drop  = push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear so a drop is never silently lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Transmit byte buffer and launch controller ahead of the UART TX.
//            Optional almost-empty interrupt: define UART_TX_FIFO_THRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = C_DEF_DEPTH,
    parameter int AW     = C_DEF_AW,
    parameter int THRESH = C_DEF_THRESH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          tx_en,
    input  logic          tx_ok,
    input  logic          ovf_clr,
    output logic [7:0]    txd_in,
    output logic          tx_start,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_irq
);

    if (DEPTH < 2 || (1 << AW) != DEPTH || THRESH < 0 || THRESH > DEPTH) begin : g_bad_params
        $error("uart_tx_fifo: inconsistent DEPTH/AW/THRESH");
    end

    tx_state_t r_state;
    tx_state_t w_state_nxt;
    logic      r_tx_ok_d;
    logic [7:0] r_txd;
    logic [7:0] w_head;
    logic      w_pop;
    logic      w_tx_start;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .ovf_clr   (ovf_clr),
        .head_data (w_head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx_ok_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_ok_d <= tx_ok;
        end
    end

    // Head byte is sampled only while idle, so it is frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txd <= 8'h00;
        end else if (r_state == ST_IDLE) begin
            r_txd <= w_head;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_en && !empty && !tx_ok) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tx_start  = 1'b1;
                w_state_nxt = tx_en ? ST_BUSY : ST_IDLE;
            end
            ST_BUSY: begin
                if (!tx_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (tx_ok && !r_tx_ok_d) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Holding here until tx_ok falls keeps tx_start clear of tx_ok.
                if (!tx_en || !tx_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign txd_in   = r_txd;
    assign tx_start = w_tx_start;

`ifdef UART_TX_FIFO_THRESH_EN
    localparam logic [AW:0] C_THRESH = (AW+1)'(THRESH);

    logic r_tx_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_irq <= 1'b0;
        end else begin
            r_tx_irq <= (count <= C_THRESH) && tx_en;
        end
    end

    assign tx_irq = r_tx_irq;
`else
    assign tx_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo (DEPTH=16, THRESH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int THRESH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          tx_en;
    logic          tx_ok;
    logic          ovf_clr;
    logic [7:0]    txd_in;
    logic          tx_start;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_irq;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .THRESH (THRESH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_en    (tx_en),
        .tx_ok    (tx_ok),
        .ovf_clr  (ovf_clr),
        .txd_in   (txd_in),
        .tx_start (tx_start),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_irq   (tx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int   t;
        logic seen;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 40) begin
            tick();
            seen = tx_start;
            t++;
        end
        chk({tag, " start"}, 32'(seen), 1);
    endtask

    // Transmitter model: launch seen, frame time, then tx_ok high for 3 cycles.
    task automatic send_frame(input string tag, input logic [7:0] exp);
        logic bad;
        wait_start(tag);
        chk({tag, " byte"}, 32'(txd_in), 32'(exp));
        repeat (3) tick();
        chk({tag, " hold"}, 32'(txd_in), 32'(exp));
        tx_ok = 1'b1;
        bad   = 1'b0;
        repeat (3) begin
            tick();
            if (tx_start) bad = 1'b1;
        end
        tx_ok = 1'b0;
        chk({tag, " no start during ok"}, 32'(bad), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_en   = 1'b0;
        tx_ok   = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) tick();

        chk("rst count",    32'(count),    0);
        chk("rst empty",    32'(empty),    1);
        chk("rst full",     32'(full),     0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst tx_start", 32'(tx_start), 0);
        chk("rst txd_in",   32'(txd_in),   0);
        chk("rst tx_irq",   32'(tx_irq),   0);
        rst_n = 1'b1;
        tick();

        // Single byte: launch two cycles after the write, pop on tx_ok rise.
        tx_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("t1 count after write", 32'(count),    1);
        chk("t1 no early start",    32'(tx_start), 0);
        tick();
        chk("t1 start pulse",       32'(tx_start), 1);
        chk("t1 txd at start",      32'(txd_in),   'hA5);
        tick();
        chk("t1 start one cycle",   32'(tx_start), 0);
        chk("t1 txd busy",          32'(txd_in),   'hA5);
        chk("t1 count busy",        32'(count),    1);
        tx_ok = 1'b1;
        tick();
        chk("t1 count popped",      32'(count),    0);
        chk("t1 empty popped",      32'(empty),    1);
        chk("t1 txd after pop",     32'(txd_in),   'hA5);
        repeat (2) tick();
        tx_ok = 1'b0;
        repeat (3) tick();
        chk("t1 idle no start",     32'(tx_start), 0);
`ifndef UART_TX_FIFO_THRESH_EN
        chk("t1 tx_irq off",        32'(tx_irq),   0);
`endif

        // Three queued bytes come out in order.
        tx_en = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        chk("t2 count 3", 32'(count), 3);
        tx_en = 1'b1;
        send_frame("t2 f0", 8'h11);
        send_frame("t2 f1", 8'h22);
        send_frame("t2 f2", 8'h33);
        repeat (3) tick();
        chk("t2 empty", 32'(empty), 1);

        // Reset in the middle of a frame discards everything.
        wr_en   = 1'b1;
        wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        wait_start("t3 pre-reset");
        tick();
        tx_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t3 mid rst count", 32'(count),    0);
        chk("t3 mid rst empty", 32'(empty),    1);
        chk("t3 mid rst txd",   32'(txd_in),   0);
        chk("t3 mid rst start", 32'(tx_start), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill past DEPTH with the transmitter disabled.
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h40 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t4 full",     32'(full),     1);
        chk("t4 count 16", 32'(count),    16);
        chk("t4 overflow", 32'(overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4 ovf cleared", 32'(overflow), 0);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        chk("t4 set wins",      32'(overflow), 1);
        chk("t4 drop count",    32'(count),    16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4 ovf cleared 2", 32'(overflow), 0);
`ifndef UART_TX_FIFO_THRESH_EN
        chk("t4 tx_irq off",    32'(tx_irq),   0);
`endif

        // Write and pop together while full: new byte lands in wrapped slot 0.
        tx_en = 1'b1;
        wait_start("t5 head");
        chk("t5 head byte", 32'(txd_in), 'h40);
        tick();
        tx_ok   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("t5 count stays 16", 32'(count),    16);
        chk("t5 still full",     32'(full),     1);
        chk("t5 no overflow",    32'(overflow), 0);
        repeat (2) tick();
        tx_ok = 1'b0;

        // Abort in BUSY: no pop, the same byte relaunches.
        wait_start("t6 launch");
        chk("t6 head byte", 32'(txd_in), 'h41);
        tick();
        tx_en = 1'b0;
        tick();
        chk("t6 count kept", 32'(count),    16);
        chk("t6 no start",   32'(tx_start), 0);
        tick();
        tx_en = 1'b1;
        send_frame("t6 relaunch", 8'h41);
        for (int i = 2; i < 16; i++) begin
            send_frame("t6 drain", 8'(8'h40 + i));
        end
        send_frame("t6 wrapped", 8'hEE);
        repeat (3) tick();
        chk("t6 empty", 32'(empty), 1);
        chk("t6 count", 32'(count), 0);

`ifdef UART_TX_FIFO_THRESH_EN
        // Almost-empty interrupt at THRESH=4.
        tx_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("t7 irq tx_en low", 32'(tx_irq), 0);
        tx_en = 1'b1;
        tick();
        chk("t7 irq at 6", 32'(tx_irq), 0);
        send_frame("t7 f0", 8'h60);
        chk("t7 count 5", 32'(count),  5);
        chk("t7 irq at 5", 32'(tx_irq), 0);
        wait_start("t7 f1");
        tick();
        tx_ok = 1'b1;
        tick();
        chk("t7 count 4",      32'(count),  4);
        chk("t7 irq not yet",  32'(tx_irq), 0);
        tick();
        chk("t7 irq rises",    32'(tx_irq), 1);
        tick();
        tx_ok = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
